// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   RV64 integer-ALU decode stage. Accepts raw 32-bit instructions from fetch,
//   screens them against the supported OP/OP-IMM/OP-32/OP-IMM-32 encodings,
//   and queues the decoded fields of legal, register-writing instructions in
//   a small FIFO for the ALU. Illegal encodings are dropped, flagged with a
//   one-cycle pulse and tallied in a saturating counter.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   inst_valid     fetch offers inst this cycle
//   inst[31:0]     raw instruction word
//   inst_ready     decoder accepts inst this cycle
//   out_valid      buffer head holds a decoded instruction
//   regA[4:0]      rs1
//   regB[11:0]     {funct7,rs2} or imm[11:0]
//   opcode[9:0]    {funct3,opcode7}
//   regDest[4:0]   rd
//   out_ready      ALU consumes the buffer head this cycle
//   illegal        one-cycle pulse after an illegal instruction is accepted
//   illegal_count  saturating count of illegal instructions
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    output logic        inst_ready,
    output logic        out_valid,
    output logic [4:0]  regA,
    output logic [11:0] regB,
    output logic [9:0]  opcode,
    output logic [4:0]  regDest,
    input  logic        out_ready,
    output logic        illegal,
    output logic [15:0] illegal_count
);
    localparam int          PW         = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [31:0]    mem [DEPTH];
    logic [DEPTH-1:0] entry_we;

    logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PW:0]    count_reg, count_next;
    logic [31:0]    head_reg, head_next;
    logic           illegal_reg;
    logic [15:0]    illegal_count_reg;

    logic           is_legal;
    logic           accept, push, pop;

    logic [6:0]     op7;
    logic [2:0]     f3;
    logic [6:0]     f7;
    logic [5:0]     f6;

    assign op7 = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];
    assign f6  = inst[31:26];

    // Legality screen. OP-IMM shifts use a 6-bit shamt, so only inst[31:26]
    // qualifies them; the 32-bit W forms use the full funct7.
    always_comb begin
        is_legal = 1'b0;
        case (op7)
            7'h13: begin
                case (f3)
                    3'd1:    is_legal = (f6 == 6'h00);
                    3'd5:    is_legal = (f6 == 6'h00) || (f6 == 6'h10);
                    default: is_legal = 1'b1;
                endcase
            end
            7'h1b: begin
                case (f3)
                    3'd0:    is_legal = 1'b1;
                    3'd1:    is_legal = (f7 == 7'h00);
                    3'd5:    is_legal = (f7 == 7'h00) || (f7 == 7'h20);
                    default: is_legal = 1'b0;
                endcase
            end
            7'h33: begin
                is_legal = (f7 == 7'h00) || (f7 == 7'h01) ||
                           ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
            end
            7'h3b: begin
                case (f7)
                    7'h01:   is_legal = (f3 == 3'd0) || (f3 >= 3'd4);
                    7'h00:   is_legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd5);
                    7'h20:   is_legal = (f3 == 3'd0) || (f3 == 3'd5);
                    default: is_legal = 1'b0;
                endcase
            end
            default: is_legal = 1'b0;
        endcase
    end

    // A full buffer still accepts when the head drains in the same cycle.
    assign inst_ready = !reset && ((count_reg != FULL_COUNT) || out_ready);
    assign out_valid  = (count_reg != '0);
    assign accept     = inst_valid && inst_ready;
    assign pop        = out_valid && out_ready;
    // rd=x0 results are architecturally dead, so they never occupy an entry.
    assign push       = accept && is_legal && (inst[11:7] != 5'd0);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_we[i]) begin
                mem[i] <= inst;
            end
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        head_next   = head_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + (PW + 1)'(1);
            2'b01:   count_next = count_reg - (PW + 1)'(1);
            default: ;
        endcase
        // The head register mirrors the entry that will be at the head next
        // cycle. When the incoming word lands exactly at the new head (buffer
        // was empty, or held one entry that is leaving) it is not in mem yet,
        // so it is bypassed. An empty buffer leaves the head untouched.
        if (count_next != '0) begin
            if (push && (wr_ptr_reg == rd_ptr_next)) begin
                head_next = inst;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            head_reg          <= '0;
            illegal_reg       <= 1'b0;
            illegal_count_reg <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            head_reg    <= head_next;
            illegal_reg <= accept && !is_legal;
            if (accept && !is_legal && (illegal_count_reg != 16'hFFFF)) begin
                illegal_count_reg <= illegal_count_reg + 16'd1;
            end
        end
    end

    assign regA          = head_reg[19:15];
    assign regB          = head_reg[31:20];
    assign opcode        = {head_reg[14:12], head_reg[6:0]};
    assign regDest       = head_reg[11:7];
    assign illegal       = illegal_reg;
    assign illegal_count = illegal_count_reg;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Self-checking bench for decode_stage. Directed scenarios followed by a
//   randomized run, all compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_decode_stage;
    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic        out_valid;
    logic [4:0]  regA;
    logic [11:0] regB;
    logic [9:0]  opcode;
    logic [4:0]  regDest;
    logic        out_ready;
    logic        illegal;
    logic [15:0] illegal_count;

    decode_stage #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_ready    (inst_ready),
        .out_valid     (out_valid),
        .regA          (regA),
        .regB          (regB),
        .opcode        (opcode),
        .regDest       (regDest),
        .out_ready     (out_ready),
        .illegal       (illegal),
        .illegal_count (illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state
    logic [31:0] q[$];
    logic [31:0] last_head;
    logic        exp_illegal;
    int          exp_illegal_count;
    int          dut_accepts;
    int          dut_emits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Which RV64 encodings the decoder supports, stated mnemonic-family-wise.
    function automatic bit ref_legal(input logic [31:0] w);
        int op, fn3, fn7, fn6;
        op  = int'(w[6:0]);
        fn3 = int'(w[14:12]);
        fn7 = int'(w[31:25]);
        fn6 = int'(w[31:26]);
        if (op == 'h13) begin
            if (fn3 == 1) return fn6 == 0;                    // slli
            if (fn3 == 5) return (fn6 == 0) || (fn6 == 'h10); // srli/srai
            return 1'b1;                                      // addi..andi
        end
        if (op == 'h1b) begin
            if (fn3 == 0) return 1'b1;                        // addiw
            if (fn3 == 1) return fn7 == 0;                    // slliw
            if (fn3 == 5) return (fn7 == 0) || (fn7 == 'h20); // srliw/sraiw
            return 1'b0;
        end
        if (op == 'h33) begin
            if ((fn7 == 0) || (fn7 == 1)) return 1'b1;        // base + M
            return (fn7 == 'h20) && ((fn3 == 0) || (fn3 == 5)); // sub/sra
        end
        if (op == 'h3b) begin
            if (fn7 == 1)    return fn3 inside {0, 4, 5, 6, 7}; // mulw/divw..
            if (fn7 == 0)    return fn3 inside {0, 1, 5};       // addw/sllw/srlw
            if (fn7 == 'h20) return fn3 inside {0, 5};          // subw/sraw
            return 1'b0;
        end
        return 1'b0;
    endfunction

    task automatic check_outputs();
        check("out_valid", out_valid, q.size() != 0);
        check("regA", regA, last_head[19:15]);
        check("regB", regB, last_head[31:20]);
        check("opcode", opcode, {last_head[14:12], last_head[6:0]});
        check("regDest", regDest, last_head[11:7]);
        check("illegal", illegal, exp_illegal);
        check("illegal_count", illegal_count, exp_illegal_count);
    endtask

    // One clock of stimulus: drive, check ready, advance, update model, check.
    task automatic cycle(input logic v, input logic [31:0] w, input logic r);
        bit acc, pop, exp_ready;
        inst_valid = v;
        inst       = w;
        out_ready  = r;
        #1;
        exp_ready = (q.size() < DEPTH) || r;
        check("inst_ready", inst_ready, exp_ready);
        if (v && inst_ready) dut_accepts++;
        if (out_valid && r)  dut_emits++;
        acc = v && exp_ready;
        pop = (q.size() != 0) && r;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        exp_illegal = 1'b0;
        if (acc) begin
            if (!ref_legal(w)) begin
                exp_illegal = 1'b1;
                if (exp_illegal_count < 65535) exp_illegal_count++;
            end else if (w[11:7] != 5'd0) begin
                q.push_back(w);
            end
        end
        if (q.size() != 0) last_head = q[0];
        check_outputs();
        $display("cycle t=%0t v=%0d inst=%08h rdy=%0d ovalid=%0d op=%03h ill=%0d cnt=%0d",
                 $time, v, w, r, out_valid, opcode, illegal, illegal_count);
    endtask

    task automatic do_reset();
        inst_valid = 1'b0;
        inst       = '0;
        out_ready  = 1'b0;
        reset      = 1'b1;
        #1;
        q.delete();
        last_head         = '0;
        exp_illegal       = 1'b0;
        exp_illegal_count = 0;
        check_outputs();
        check("inst_ready_in_reset", inst_ready, 1'b0);
        @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
        $display("reset t=%0t", $time);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w[6:0] = 7'h13;
            1: w[6:0] = 7'h1b;
            2: w[6:0] = 7'h33;
            3: w[6:0] = 7'h3b;
            4: w[6:0] = 7'h37;
            default: ;
        endcase
        case ($urandom_range(0, 4))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            3: w[31:25] = 7'h10;
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    initial begin
        int acc0, emit0;
        reset      = 1'b0;
        inst_valid = 1'b0;
        inst       = '0;
        out_ready  = 1'b0;
        q.delete();
        last_head         = '0;
        exp_illegal       = 1'b0;
        exp_illegal_count = 0;
        dut_accepts       = 0;
        dut_emits         = 0;
        #2;
        do_reset();

        // addi x1,x2,5 appears one cycle after acceptance
        cycle(1'b1, 32'h00510093, 1'b1);
        check("addi_valid", out_valid, 1'b1);
        check("addi_regA", regA, 5'd2);
        check("addi_regB", regB, 12'h005);
        check("addi_opcode", opcode, 10'h013);
        check("addi_regDest", regDest, 5'd1);
        cycle(1'b0, 32'h0, 1'b1);

        // back-to-back fill, stall, then drain in order
        cycle(1'b1, 32'h00510093, 1'b0);
        cycle(1'b1, 32'h002081B3, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        check("full_ready", inst_ready, 1'b0);
        check("head_first", opcode, 10'h013);
        cycle(1'b0, 32'h0, 1'b1);
        check("add_opcode", opcode, 10'h033);
        check("add_regA", regA, 5'd1);
        check("add_regB", regB, 12'h002);
        check("add_regDest", regDest, 5'd3);
        cycle(1'b0, 32'h0, 1'b1);
        check("drained", out_valid, 1'b0);

        // illegal encodings: lui, and OP with funct7=0x10
        cycle(1'b1, 32'h000000B7, 1'b1);
        check("lui_illegal", illegal, 1'b1);
        cycle(1'b1, 32'h202081B3, 1'b1);
        check("f7_illegal", illegal, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        check("illegal_pulse_end", illegal, 1'b0);
        check("illegal_count_2", illegal_count, 16'd2);
        check("illegal_no_valid", out_valid, 1'b0);

        // nop to x0 is swallowed silently
        cycle(1'b1, 32'h00000013, 1'b1);
        check("nop_valid", out_valid, 1'b0);
        check("nop_illegal", illegal, 1'b0);

        // full-throughput streaming with the buffer full
        cycle(1'b1, 32'h00510093, 1'b0);
        cycle(1'b1, 32'h002081B3, 1'b0);
        acc0  = dut_accepts;
        emit0 = dut_emits;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, {7'h00, 5'(i), 5'd3, 3'd0, 5'(i + 1), 7'h33}, 1'b1);
        end
        check("stream_accepts", dut_accepts - acc0, 10);
        check("stream_emits", dut_emits - emit0, 10);
        check("stream_full", inst_ready, 1'b1);
        do_reset();

        // first acceptance right after reset release
        cycle(1'b1, 32'h00510093, 1'b0);
        check("post_reset_accept", out_valid, 1'b1);

        // randomized traffic, with one mid-run reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of decoded-instruction buffer entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports inst_valid  input  1 and inst  input  32: raw RV64 instruction offered by fetch.
REQ-005 SHALL have port inst_ready  output  1  decoder can accept inst this cycle.
REQ-006 SHALL have port out_valid  output  1  buffer head holds a decoded instruction.
REQ-007 SHALL have ports regA  output  5 (rs1), regB  output  12 ({funct7,rs2} or imm[11:0]), opcode  output  10 ({funct3,opcode7}), regDest  output  5 (rd).
REQ-008 SHALL have port out_ready  input  1  ALU consumes buffer head this cycle.
REQ-009 SHALL have ports illegal  output  1 (one-cycle pulse) and illegal_count  output  16 (saturating count of illegal instructions).

Function
REQ-010 Transfer in: inst_valid && inst_ready; transfer out: out_valid && out_ready.
REQ-011 Field extraction: regA=inst[19:15], regB=inst[31:20], regDest=inst[11:7], opcode={inst[14:12],inst[6:0]}.
REQ-012 Legal set: opcode7 0x13 any funct3, except funct3=1 requires inst[31:26]=0 and funct3=5 requires inst[31:26] in {0x00,0x10}.
REQ-013 Legal set: opcode7 0x1b with funct3 0; funct3 1 with funct7=0x00; funct3 5 with funct7 in {0x00,0x20}.
REQ-014 Legal set: opcode7 0x33 with funct7 in {0x00,0x01} any funct3, or funct7=0x20 with funct3 in {0,5}.
REQ-015 Legal set: opcode7 0x3b with funct7=0x01 and funct3 in {0,4,5,6,7}, or funct7 in {0x00,0x20} per RV64 (add/sub/sll/srl/sra W forms); all other encodings illegal.
REQ-016 Accepted legal instruction with regDest!=0 SHALL be written to buffer tail; visible at outputs no earlier than the next cycle (1-cycle latency when empty).
REQ-017 Accepted legal instruction with regDest=0 SHALL be consumed and discarded (no buffer entry, no illegal pulse).
REQ-018 Accepted illegal instruction SHALL be discarded, assert illegal the following cycle for exactly one cycle, increment illegal_count saturating at 0xFFFF.
REQ-019 inst_ready SHALL be 1 when buffer occupancy < DEPTH, or when occupancy = DEPTH and out_ready=1 in the same cycle (full-throughput pop-and-push).
REQ-020 Simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-021 out_valid SHALL equal (occupancy != 0); output fields SHALL be driven from buffer head, stable while out_valid && !out_ready.
REQ-022 When out_valid=0, output fields SHALL hold their last value (no X).
REQ-023 Ordering SHALL be strictly FIFO; one instruction accepted and one emitted per cycle maximum.

Reset
REQ-024 While reset=1: occupancy=0, pointers=0, out_valid=0, illegal=0, illegal_count=0, inst_ready=0, regA/regB/opcode/regDest=0.
REQ-025 Reset asserted mid-operation SHALL discard all buffered entries immediately; first acceptance possible on the first clk edge after reset deasserts.

Verification
REQ-026 Send 0x00510093 (addi x1,x2,5), out_ready=1 -> next cycle out_valid=1, regA=2, regB=0x005, opcode=0x013, regDest=1.
REQ-027 Back-to-back 0x00510093 then 0x002081B3 (add x3,x1,x2), out_ready=0 -> inst_ready=0 after 2 accepts; raise out_ready -> emits opcode 0x013 then 0x033 (regA=1, regB=0x002, regDest=3), in order.
REQ-028 Send 0x000000B7 (lui) and 0x402081B3 with funct7 changed to 0x10 -> each produces one illegal pulse, no out_valid, illegal_count=2.
REQ-029 Send 0x00000013 (addi x0,x0,0) -> inst accepted, out_valid stays 0, illegal stays 0.
REQ-030 Full buffer with out_ready=1 and inst_valid=1 for 10 cycles -> 10 accepts, 10 emits, occupancy stays DEPTH; assert reset mid-stream -> out_valid=0 same cycle, illegal_count=0.
